// File: rtl/spi_reg_writer.sv
// SPI mode-0 write-only register port for the PWM block.
// Five 8-bit config registers loaded from 16-bit MSB-first frames.
module spi_reg_writer #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_copi,
  input  logic       spi_ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_t;

  localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sclk_q, copi_q, ncs_q;
  logic sclk_d, ncs_d;
  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, ncs_rise, ncs_fall;

  logic [4:0]  cnt, cnt_nx;
  logic [15:0] sr, sr_nx;
  logic        wr_nx, err_nx;

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign copi_s = copi_q[SYNC_STAGES-1];
  assign ncs_s  = ncs_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_d;
  assign ncs_rise  = ncs_s & ~ncs_d;
  assign ncs_fall  = ~ncs_s & ncs_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= '0;
      copi_q <= '0;
      ncs_q  <= '1;
      sclk_d <= 1'b0;
      ncs_d  <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
      copi_q <= {copi_q[SYNC_STAGES-2:0], spi_copi};
      ncs_q  <= {ncs_q[SYNC_STAGES-2:0], spi_ncs};
      sclk_d <= sclk_s;
      ncs_d  <= ncs_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      sr        <= sr_nx;
      wr_strobe <= wr_nx;
      frame_err <= err_nx;
    end
  end

  // ncs rise takes priority over a coincident sclk rise
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sr_nx    = sr;
    wr_nx    = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (ncs_fall) begin
          cnt_nx   = '0;
          sr_nx    = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          if (cnt == 5'd16) begin
            state_nx = COMMIT;
          end else begin
            state_nx = IDLE;
            err_nx   = 1'b1;
          end
        end else if (sclk_rise) begin
          if (cnt < 5'd16) sr_nx = {sr[14:0], copi_s};
          if (cnt < 5'd17) cnt_nx = cnt + 5'd1;
        end
      end
      COMMIT: begin
        state_nx = IDLE;
        wr_nx    = sr[15] && (sr[14:8] <= MAX_A);
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else if (wr_nx) begin
      case (sr[14:8])
        7'd0: en_reg_out_7_0  <= sr[7:0];
        7'd1: en_reg_out_15_8 <= sr[7:0];
        7'd2: en_reg_pwm_7_0  <= sr[7:0];
        7'd3: en_reg_pwm_15_8 <= sr[7:0];
        7'd4: pwm_duty_cycle  <= sr[7:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_writer.sv
// Scoreboard bench for spi_reg_writer.
// Directed frames followed by randomized frames against a register-file model.
module tb_spi_reg_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_sclk = 1'b0;
  logic spi_copi = 1'b0;
  logic spi_ncs = 1'b1;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic wr_strobe, frame_err;

  spi_reg_writer #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
    .clk(clk),
    .rst(rst),
    .spi_sclk(spi_sclk),
    .spi_copi(spi_copi),
    .spi_ncs(spi_ncs),
    .en_reg_out_7_0(en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle),
    .wr_strobe(wr_strobe),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [39:0] snap;
  } exp_t;

  int checks = 0;
  int errors = 0;
  logic [7:0] m [5];
  exp_t q[$];
  exp_t e;

  wire [39:0] dut_snap = {pwm_duty_cycle, en_reg_pwm_15_8,
                          en_reg_pwm_7_0, en_reg_out_15_8,
                          en_reg_out_7_0};

  function automatic logic [39:0] model_snap();
    return {m[4], m[3], m[2], m[1], m[0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (wr_strobe || frame_err)) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", 64'({wr_strobe, frame_err}), 64'd0);
      end else begin
        e = q.pop_front();
        check("pulse_kind", 64'({wr_strobe, frame_err}),
              e.is_err ? 64'd1 : 64'd2);
        check("regs_at_pulse", 64'(dut_snap), 64'(e.snap));
      end
    end
  end

  task automatic check_idle(input string name);
    check({name, "_drain"}, 64'(q.size()), 64'd0);
    check({name, "_regs"}, 64'(dut_snap), 64'(model_snap()));
    check({name, "_quiet"}, 64'({wr_strobe, frame_err}), 64'd0);
    q.delete();
  endtask

  // Expected outcome comes from frame length and field values only
  task automatic predict(input logic [31:0] w, input int len);
    exp_t x;
    if (len != 16) begin
      x.is_err = 1'b1;
      x.snap   = model_snap();
      q.push_back(x);
    end else if (w[15] && w[14:8] <= 7'd4) begin
      m[int'(w[14:8])] = w[7:0];
      x.is_err = 1'b0;
      x.snap   = model_snap();
      q.push_back(x);
    end
  endtask

  task automatic send_bits(input logic [31:0] w, input int len);
    for (int i = len - 1; i >= 0; i--) begin
      spi_copi = w[i];
      #40 spi_sclk = 1'b1;
      #40 spi_sclk = 1'b0;
    end
  endtask

  task automatic frame(input string name, input logic [31:0] w,
                       input int len);
    @(negedge clk);
    predict(w, len);
    spi_ncs = 1'b0;
    #80;
    send_bits(w, len);
    #40 spi_ncs = 1'b1;
    #200;
    check_idle(name);
  endtask

  initial begin
    logic [31:0] w;
    int len;
    for (int i = 0; i < 5; i++) m[i] = 8'h00;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_regs", 64'(dut_snap), 64'd0);
    check("reset_pulses", 64'({wr_strobe, frame_err}), 64'd0);
    repeat (40) @(negedge clk);
    check_idle("idle");

    frame("w_out0", 32'h80A5, 16);
    check("out0_val", 64'(en_reg_out_7_0), 64'hA5);
    frame("w_duty", 32'h8480, 16);
    check("duty_val", 64'(pwm_duty_cycle), 64'h80);

    frame("w_pwm1", 32'h83F0, 16);
    frame("rd_pwm1", 32'h0355, 16);
    check("pwm1_hold", 64'(en_reg_pwm_15_8), 64'hF0);

    frame("addr5", 32'h8577, 16);

    frame("len15", 32'h4119, 15);
    frame("len17", 32'h10466, 17);
    check("pwm0_hold", 64'(en_reg_pwm_7_0), 64'h00);
    frame("w_pwm0", 32'h8233, 16);
    check("pwm0_val", 64'(en_reg_pwm_7_0), 64'h33);

    frame("w_out1", 32'h8111, 16);
    @(negedge clk);
    spi_ncs = 1'b0;
    #80;
    send_bits(32'h81, 8);
    @(negedge clk);
    rst = 1'b1;
    spi_ncs = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) m[i] = 8'h00;
    repeat (20) @(negedge clk);
    check("midrst_out1", 64'(en_reg_out_15_8), 64'h00);
    check_idle("midrst");
    frame("w_out1b", 32'h81C3, 16);
    check("out1_val", 64'(en_reg_out_15_8), 64'hC3);

    for (int n = 0; n < 60; n++) begin
      w = $urandom;
      if ($urandom_range(0, 3) != 0) w[14:8] = 7'($urandom_range(0, 6));
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 20) : 16;
      frame("rand", w, len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
